// File: rtl/fp8_to_fixed.sv
// fp8_to_fixed
//   Iterative decoder from the adder's 8-bit float ([7]=S, [6:4]=E, [3:0]=F,
//   value = (-1)^S * 1.F * 2^(E-BIAS)) to signed Q(OUT_W-FRAC_W).FRAC_W.
//   The magnitude moves one bit per cycle, so a result takes |sh|+1 cycles
//   after accept and one op occupies the block for |sh|+3 cycles.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    operand handshake; in_ready is high only in IDLE
//   in_data[7:0]         float operand, sampled only at accept
//   out_valid/out_ready  result handshake; result held until accepted
//   out_data[OUT_W-1:0]  signed fixed-point result
//   out_ovf              magnitude did not fit OUT_W-1 bits (with out_valid)
//
// Configuration
//   FP8_TO_FIXED_SAT_EN  when defined, overflowing results saturate to the
//                        most positive/negative code; otherwise they wrap.
module fp8_to_fixed #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8,
  parameter int BIAS   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  // sh = E - BIAS - 4 + FRAC_W is monotonic in E, so the extremes are E=0/7.
  localparam int SH_LO  = FRAC_W - BIAS - 4;
  localparam int SH_HI  = SH_LO + 7;
  localparam int ABS_LO = (SH_LO < 0) ? -SH_LO : SH_LO;
  localparam int ABS_HI = (SH_HI < 0) ? -SH_HI : SH_HI;
  localparam int MAXN   = (ABS_LO > ABS_HI) ? ABS_LO : ABS_HI;
  localparam int CNT_W  = (MAXN < 2) ? 1 : $clog2(MAXN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               sgn_q, sgn_d;
  logic               left_q, left_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               oovf_q, oovf_d;

  // Operand decode
  int                 sh, n_full;
  logic               is_zero;
  logic [CNT_W-1:0]   n;

  always_comb begin
    sh      = int'(in_data[6:4]) + SH_LO;
    n_full  = (sh < 0) ? -sh : sh;
    is_zero = (in_data[6:0] == 7'd0);   // sign ignored: 0x80 decodes to 0
    n       = is_zero ? '0 : n_full[CNT_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = (n != '0) ? SHIFT : SIGN;
      SHIFT: if (cnt_q == CNT_W'(1)) state_d = SIGN;
      SIGN:  state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = data_q;
    out_ovf   = oovf_q;
  end

  // Datapath
  logic             ovf_fin;
  logic [OUT_W-1:0] signed_mag;

  always_comb begin
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sgn_d      = sgn_q;
    left_d     = left_q;
    data_d     = data_q;
    oovf_d     = oovf_q;
    // Magnitude must fit OUT_W-1 bits, so -2^(OUT_W-1) also counts as overflow.
    ovf_fin    = ovf_q | mag_q[OUT_W-1];
    signed_mag = sgn_q ? (~mag_q + OUT_W'(1)) : mag_q;
    case (state_q)
      IDLE: if (in_valid) begin
        mag_d  = is_zero ? '0 : OUT_W'({1'b1, in_data[3:0]});
        cnt_d  = n;
        ovf_d  = 1'b0;
        sgn_d  = in_data[7];
        left_d = (sh > 0);
      end
      SHIFT: begin
        if (left_q) begin
          ovf_d = ovf_q | mag_q[OUT_W-1];   // sticky: a 1 leaves the top
          mag_d = mag_q << 1;
        end else begin
          mag_d = mag_q >> 1;               // truncation toward zero
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      SIGN: begin
        ovf_d  = ovf_fin;
        oovf_d = ovf_fin;
`ifdef FP8_TO_FIXED_SAT_EN
        if (ovf_fin)
          data_d = sgn_q ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
          data_d = signed_mag;
`else
        data_d = signed_mag;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      sgn_q  <= 1'b0;
      left_q <= 1'b0;
      data_q <= '0;
      oovf_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      sgn_q  <= sgn_d;
      left_q <= left_d;
      data_q <= data_d;
      oovf_q <= oovf_d;
    end
  end

endmodule

// File: tb/tb_fp8_to_fixed.sv
// tb_fp8_to_fixed
//   Drives a 16-bit and a 12-bit instance with the same directed operands.
//   A behavioural model (integer arithmetic on the float value) predicts each
//   result and its latency; a compare process checks every valid output cycle,
//   and directed steps check hand-computed literals.
module tb_fp8_to_fixed;

  localparam int FRAC_W = 8;
  localparam int BIAS   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b1;
  logic        in_ready0, in_ready1, ov0, ov1, ovf0, ovf1;
  logic [15:0] d0;
  logic [11:0] d1;

  always #5 clk = ~clk;

  fp8_to_fixed #(.OUT_W(16), .FRAC_W(FRAC_W), .BIAS(BIAS)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_data(d0), .out_ovf(ovf0));

  fp8_to_fixed #(.OUT_W(12), .FRAC_W(FRAC_W), .BIAS(BIAS)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(d1), .out_ovf(ovf1));

  typedef struct {
    logic [15:0] d16;
    logic        o16;
    logic [15:0] d12;
    logic        o12;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Value-level model: scale 1.F by 2^(E-BIAS) into FRAC_W fraction bits.
  function automatic void model(input logic [7:0] d, input int w,
                                output logic [15:0] data, output logic ovf,
                                output int lat);
    int    sh;
    longint m, mag, v, lim;
    sh  = int'(d[6:4]) - BIAS - 4 + FRAC_W;
    m   = 16 + longint'(d[3:0]);
    if (d[6:0] == 7'd0)  mag = 0;
    else if (sh >= 0)    mag = m << sh;
    else                 mag = m >> (-sh);
    lim = longint'(1) << (w - 1);
    ovf = (mag >= lim);
    v   = d[7] ? -mag : mag;
`ifdef FP8_TO_FIXED_SAT_EN
    if (ovf) v = d[7] ? -lim : lim - 1;
`endif
    v    = v & ((longint'(1) << w) - 1);
    data = v[15:0];
    lat  = (d[6:0] == 7'd0) ? 1 : ((sh < 0) ? -sh : sh) + 1;
  endfunction

  // Handshake monitor: records accepted operands and retires results.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (ov0 && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready0) begin
        model(in_data, 16, e.d16, e.o16, e.lat);
        model(in_data, 12, e.d12, e.o12, e.lat);
        e.acc = cyc + 1;
        q.push_back(e);
        acc_cnt++;
      end
    end
    cyc++;
  end

  // Compare process: every cycle with a valid result.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov <= 1'b0;
    end else begin
      if (in_ready0 !== in_ready1) chk("in_ready_w12", in_ready1, in_ready0);
      if (ov0 || ov1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(ov0), 32'(0));
        end else begin
          chk("valid_w12", ov1, ov0);
          chk("data_w16", d0, q[0].d16);
          chk("ovf_w16", ovf0, q[0].o16);
          chk("data_w12", d1, q[0].d12);
          chk("ovf_w12", ovf1, q[0].o12);
          if (!prev_ov) chk("latency", cyc - q[0].acc, q[0].lat);
        end
      end
      prev_ov <= ov0;
    end
  end

  task automatic send(input logic [7:0] d);
    int k;
    k = 0;
    while (!in_ready0 && k < 40) begin @(negedge clk); k++; end
    if (!in_ready0) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [15:0] e16, input logic e_o16,
                          input logic [11:0] e12, input logic e_o12);
    int k;
    k = 0;
    while (!ov0 && k < 40) begin @(negedge clk); k++; end
    if (!ov0) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_d16"}, d0, e16);
      chk({name, "_o16"}, ovf0, e_o16);
      chk({name, "_d12"}, d1, e12);
      chk({name, "_o12"}, ovf1, e_o12);
    end
  endtask

`ifdef FP8_TO_FIXED_SAT_EN
  localparam logic [11:0] W12_7F = 12'h7FF, W12_FF = 12'h800, W12_70 = 12'h7FF, W12_F0 = 12'h800;
`else
  localparam logic [11:0] W12_7F = 12'hF00, W12_FF = 12'h100, W12_70 = 12'h000, W12_F0 = 12'h000;
`endif

  initial begin
    int a0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", ov0, 0);
    chk("rst_data", d0, 0);
    chk("rst_ovf", ovf0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);

    // Directed operands with literal expectations
    send(8'h38); wait_res("p1p5",  16'h0180, 0, 12'h180, 0);
    send(8'hB0); wait_res("m1p0",  16'hFF00, 0, 12'hF00, 0);
    send(8'h7F); wait_res("p31",   16'h1F00, 0, W12_7F, 1);
    send(8'hFF); wait_res("m31",   16'hE100, 0, W12_FF, 1);
    send(8'h00); wait_res("zero",  16'h0000, 0, 12'h000, 0);
    send(8'h80); wait_res("nzero", 16'h0000, 0, 12'h000, 0);
    send(8'h0F); wait_res("e0f15", 16'h003E, 0, 12'h03E, 0);
    send(8'h70); wait_res("p16",   16'h1000, 0, W12_70, 1);
    send(8'hF0); wait_res("m16",   16'hF000, 0, W12_F0, 1);

    // Back-to-back zeros: one accept every 3 cycles
    @(negedge clk);
    a0 = acc_cnt;
    in_valid = 1'b1; in_data = 8'h00;
    repeat (12) @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepts", acc_cnt - a0, 4);
    repeat (3) @(negedge clk);

    // in_valid while busy is ignored
    send(8'h7F);
    in_valid = 1'b1; in_data = 8'h38;
    repeat (4) begin chk("busy_in_ready", in_ready0, 0); @(negedge clk); end
    in_valid = 1'b0;
    wait_res("busy_p31", 16'h1F00, 0, W12_7F, 1);

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h38);
    wait_res("bp", 16'h0180, 0, 12'h180, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", ov0, 1);
      chk("bp_data", d0, 16'h0180);
      chk("bp_in_ready", in_ready0, 0);
    end
    a0 = acc_cnt;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hB0;
    @(negedge clk);
    chk("bp_release_valid", ov0, 0);
    chk("bp_release_ready", in_ready0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accept", acc_cnt - a0, 1);
    wait_res("bp_next", 16'hFF00, 0, 12'hF00, 0);

    // Reset abort mid-SHIFT
    send(8'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", ov0, 0);
    chk("abort_data16", d0, 0);
    chk("abort_data12", d1, 0);
    chk("abort_ovf12", ovf1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h38); wait_res("post_rst", 16'h0180, 0, 12'h180, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
